// File: rtl/bus_xfer_sequencer_if.sv
// Request handshake and enable bundle between the control unit and
// the register-transfer sequencer.
interface bus_xfer_sequencer_if;
    logic        req_valid;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic        req_ready;
    logic [23:0] src_out;
    logic [23:0] dst_in;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output req_valid,
        output req_src,
        output req_dst,
        input  req_ready,
        input  src_out,
        input  dst_in,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_src,
        input  req_dst,
        output req_ready,
        output src_out,
        output dst_in,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// Sequences one register transfer: drive the source onto the bus,
// let it settle, then pulse the destination load enable.
module bus_xfer_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 4
) (
    input logic                clk,
    input logic                reset_n,
    bus_xfer_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        LOAD,
        DONE,
        ERR
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [4:0]       CODE_LIM = 5'd24;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       src_q, src_d;
    logic [4:0]       dst_q, dst_d;

    logic [23:0] src_out_q, src_out_d;
    logic [23:0] dst_in_q, dst_in_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        hs;
    logic        bad_code;

    // Codes 24..31 decode to no enable at all.
    function automatic logic [23:0] dec24(input logic [4:0] c);
        logic [23:0] d;
        d = '0;
        for (int i = 0; i < 24; i++) begin
            d[i] = (c == 5'(i));
        end
        return d;
    endfunction

    assign hs       = bus.req_valid && ready_q;
    assign bad_code = (bus.req_src >= CODE_LIM) ||
                      (bus.req_dst >= CODE_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    src_d = bus.req_src;
                    dst_d = bus.req_dst;
                    if (bad_code) begin
                        state_d = ERR;
                    end else begin
                        state_d = DRIVE;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered.
    always_comb begin
        src_out_d = '0;
        dst_in_d  = '0;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        unique case (state_d)
            IDLE: ready_d = 1'b1;
            DRIVE: begin
                src_out_d = dec24(src_d);
                busy_d    = 1'b1;
            end
            LOAD: begin
                src_out_d = dec24(src_d);
                dst_in_d  = dec24(dst_d);
                busy_d    = 1'b1;
            end
            DONE:    done_d = 1'b1;
            ERR:     err_d  = 1'b1;
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            src_out_q <= '0;
            dst_in_q  <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            src_out_q <= src_out_d;
            dst_in_q  <= dst_in_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.src_out   = src_out_q;
    assign bus.dst_in    = dst_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: two instances (settle 1 and 3) share
// one request stream and are checked against a timeline model.
module tb_bus_xfer_sequencer;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic [4:0] req_src;
    logic [4:0] req_dst;

    int checks;
    int errors;

    bus_xfer_sequencer_if if1 ();
    bus_xfer_sequencer_if if3 ();

    assign if1.req_valid = req_valid;
    assign if1.req_src   = req_src;
    assign if1.req_dst   = req_dst;
    assign if3.req_valid = req_valid;
    assign if3.req_src   = req_src;
    assign if3.req_dst   = req_dst;

    bus_xfer_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) u_s1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1.slave)
    );

    bus_xfer_sequencer #(.SETTLE_CYCLES(3), .CNT_W(4)) u_s3 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] s;
        logic [23:0] d;
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic        er;
    } exp_t;

    // Model: t = cycles since the handshake (0 = idle and ready).
    int  t   [2];
    int  ms  [2];
    int  md  [2];
    bit  bad [2];
    int  sv  [2];
    bit  armed;

    initial begin
        sv[0] = 1;
        sv[1] = 3;
        armed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t[i]   = 0;
            ms[i]  = 0;
            md[i]  = 0;
            bad[i] = 1'b0;
        end
    end

    function automatic exp_t exp_out(input int tt, input int s,
                                     input bit b, input int sc,
                                     input int dc);
        exp_t e;
        e     = '0;
        e.rdy = (tt == 0);
        if (tt != 0) begin
            if (b) begin
                e.er = (tt == 1);
            end else if (tt <= s + 1) begin
                e.s   = 24'(1) << sc;
                e.bsy = 1'b1;
                if (tt == s + 1) e.d = 24'(1) << dc;
            end else begin
                e.dn = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                t[i]  = 0;
                armed = 1'b1;
            end else if (t[i] == 0) begin
                if (req_valid) begin
                    t[i]   = 1;
                    ms[i]  = int'(req_src);
                    md[i]  = int'(req_dst);
                    bad[i] = (req_src >= 5'd24) || (req_dst >= 5'd24);
                end
            end else begin
                t[i] = t[i] + 1;
                if (bad[i] ? (t[i] > 1) : (t[i] > sv[i] + 2)) t[i] = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [23:0] act,
                       input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input string p, input exp_t e,
                           input logic [23:0] so, input logic [23:0] di,
                           input logic rdy, input logic bsy,
                           input logic dn, input logic er);
        chk({p, "_src_out"}, so, e.s);
        chk({p, "_dst_in"}, di, e.d);
        chk({p, "_ready"}, 24'(rdy), 24'(e.rdy));
        chk({p, "_busy"}, 24'(bsy), 24'(e.bsy));
        chk({p, "_done"}, 24'(dn), 24'(e.dn));
        chk({p, "_err"}, 24'(er), 24'(e.er));
        chk({p, "_onehot_src"}, 24'($onehot0(so)), 24'(1));
        chk({p, "_onehot_dst"}, 24'($onehot0(di)), 24'(1));
        chk({p, "_dst_wo_src"}, 24'((|di) && !(|so)), 24'(0));
        chk({p, "_done_err"}, 24'(dn && er), 24'(0));
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk_dut("s1", exp_out(t[0], sv[0], bad[0], ms[0], md[0]),
                    if1.src_out, if1.dst_in, if1.req_ready,
                    if1.busy, if1.done, if1.err);
            chk_dut("s3", exp_out(t[1], sv[1], bad[1], ms[1], md[1]),
                    if3.src_out, if3.dst_in, if3.req_ready,
                    if3.busy, if3.done, if3.err);
        end
    end

    logic [4:0] tbl_s [6];
    logic [4:0] tbl_d [6];

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        tbl_s = '{5'd23, 5'd24, 5'd0, 5'd15, 5'd3, 5'd16};
        tbl_d = '{5'd23, 5'd0, 5'd0, 5'd23, 5'd3, 5'd30};

        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_ready", 24'(if1.req_ready), 24'(1));
        chk("rst_src", if1.src_out, 24'h0);
        chk("rst_dst", if3.dst_in, 24'h0);
        chk("rst_busy", 24'(if3.busy), 24'(0));
        @(negedge clk);

        // basic transfer R1 -> R2; codes scrambled after handshake
        req_valid = 1'b1; req_src = 5'd1; req_dst = 5'd2;
        @(negedge clk);
        req_valid = 1'b0; req_src = 5'd9; req_dst = 5'd9;
        chk("b1_src", if1.src_out, 24'h000002);
        chk("b1_dst", if1.dst_in, 24'h000000);
        @(negedge clk);
        chk("b2_src", if1.src_out, 24'h000002);
        chk("b2_dst", if1.dst_in, 24'h000004);
        @(negedge clk);
        chk("b3_done", 24'(if1.done), 24'(1));
        repeat (4) @(negedge clk);

        // long settle MDR -> IR
        req_valid = 1'b1; req_src = 5'd21; req_dst = 5'd22;
        @(negedge clk);
        req_valid = 1'b0;
        chk("l1_src", if3.src_out, 24'h200000);
        @(negedge clk);
        @(negedge clk);
        chk("l3_src", if3.src_out, 24'h200000);
        chk("l3_dst", if3.dst_in, 24'h000000);
        @(negedge clk);
        chk("l4_dst", if3.dst_in, 24'h400000);
        @(negedge clk);
        chk("l5_done", 24'(if3.done), 24'(1));
        repeat (2) @(negedge clk);

        // invalid codes
        req_valid = 1'b1; req_src = 5'd25; req_dst = 5'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("i1_err", 24'(if1.err), 24'(1));
        chk("i1_src", if3.src_out, 24'h0);
        @(negedge clk);
        chk("i2_ready", 24'(if3.req_ready), 24'(1));
        req_valid = 1'b1; req_src = 5'd0; req_dst = 5'd31;
        @(negedge clk);
        req_valid = 1'b0;
        chk("i3_err", 24'(if3.err), 24'(1));
        @(negedge clk);
        chk("i4_ready", 24'(if1.req_ready), 24'(1));
        @(negedge clk);

        // back-to-back with req_valid held
        req_valid = 1'b1; req_src = 5'd20; req_dst = 5'd20;
        @(negedge clk);
        req_src = 5'd16; req_dst = 5'd5;
        chk("bb1_src", if1.src_out, 24'h100000);
        repeat (3) @(negedge clk);
        chk("bb4_ready", 24'(if1.req_ready), 24'(1));
        @(negedge clk);
        chk("bb5_src", if1.src_out, 24'h010000);
        @(negedge clk);
        chk("bb6_ready", 24'(if3.req_ready), 24'(1));
        @(negedge clk);
        req_valid = 1'b0;
        chk("bb7_src", if3.src_out, 24'h010000);
        repeat (6) @(negedge clk);

        // reset during LOAD
        req_valid = 1'b1; req_src = 5'd3; req_dst = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("r2_src", if1.src_out, 24'h000008);
        chk("r2_dst", if1.dst_in, 24'h000080);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("r3_src", if1.src_out, 24'h0);
        chk("r3_dst", if1.dst_in, 24'h0);
        chk("r3_ready", 24'(if1.req_ready), 24'(1));
        @(negedge clk);
        chk("r4_done", 24'(if1.done), 24'(0));
        @(negedge clk);

        // edge-code vectors, checked by the model
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_src   = tbl_s[i];
            req_dst   = tbl_d[i];
            @(negedge clk);
            req_valid = 1'b0;
            repeat (7) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
